// File: rtl/pipe_pkg.sv
// Shared pipeline types for the decode/issue stage: datapath widths,
// forwarding-select encoding and the ID/EX register bundle.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 4;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [REG_W-1:0]  rd;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass select: x0 reads zero, EX/MEM beats MEM/WB,
// otherwise the register-file read data is used.
module fwd_mux
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] idx_i,
  input  logic [XLEN-1:0]  rf_data_i,
  input  logic             exmem_we_i,
  input  logic [REG_W-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]  exmem_data_i,
  input  logic             memwb_we_i,
  input  logic [REG_W-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]  memwb_data_i,
  output logic [XLEN-1:0]  data_o,
  output fwd_sel_e         sel_o
);

  // NOTE: every output gets a default before the if-chain so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_o  = FWD_RF;
    data_o = rf_data_i;
    if (idx_i == '0) begin
      data_o = '0;
    end else if (exmem_we_i && (exmem_rd_i == idx_i)) begin
      sel_o  = FWD_EXMEM;
      data_o = exmem_data_i;
    end else if (memwb_we_i && (memwb_rd_i == idx_i)) begin
      // Covers the register-file write landing this same cycle.
      sel_o  = FWD_MEMWB;
      data_o = memwb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_issue.sv
// Decode/issue stage: register-file read, operand forwarding, load-use
// bubble insertion and the ID/EX pipeline register.
module id_ex_issue #(
  parameter int XLEN   = pipe_pkg::XLEN,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [CTRL_W-1:0] id_alu_ctrl,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  output logic [4:0]        rf_rs1,
  output logic [4:0]        rf_rs2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_rd,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic              memwb_reg_write,
  input  logic [4:0]        memwb_rd,
  input  logic [XLEN-1:0]   memwb_result,
  input  logic              ex_flush,
  input  logic              ex_stall,
  output logic              id_stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_alu_ctrl,
  output logic [XLEN-1:0]   ex_op_a,
  output logic [XLEN-1:0]   ex_op_b,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  import pipe_pkg::*;

  // id_ex_t is sized by the package; XLEN/CTRL_W must match it.
  id_ex_t           ex_d, ex_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [XLEN-1:0]  fwd_a, fwd_b;
  fwd_sel_e         sel_a, sel_b;
  logic             hz;
  logic             unused_sel;

  assign rf_rs1     = id_rs1;
  assign rf_rs2     = id_rs2;
  assign unused_sel = ^{sel_a, sel_b};

  fwd_mux u_fwd_a (
    .idx_i        (id_rs1),
    .rf_data_i    (rf_rdata1),
    .exmem_we_i   (exmem_reg_write),
    .exmem_rd_i   (exmem_rd),
    .exmem_data_i (exmem_result),
    .memwb_we_i   (memwb_reg_write),
    .memwb_rd_i   (memwb_rd),
    .memwb_data_i (memwb_result),
    .data_o       (fwd_a),
    .sel_o        (sel_a)
  );

  fwd_mux u_fwd_b (
    .idx_i        (id_rs2),
    .rf_data_i    (rf_rdata2),
    .exmem_we_i   (exmem_reg_write),
    .exmem_rd_i   (exmem_rd),
    .exmem_data_i (exmem_result),
    .memwb_we_i   (memwb_reg_write),
    .memwb_rd_i   (memwb_rd),
    .memwb_data_i (memwb_result),
    .data_o       (fwd_b),
    .sel_o        (sel_b)
  );

  // A load in EX has no data to forward yet; its consumer must wait one cycle.
  assign hz = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
              ((id_use_rs1 & (id_rs1 == ex_q.rd)) |
               (id_use_rs2 & (id_rs2 == ex_q.rd)));

  assign id_stall = (hz | ex_stall) & ~ex_flush;

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (ex_flush) begin
      ex_d = '0;
    end else if (!ex_stall) begin
      if (hz) begin
        // Bubble: kill control only, remaining fields are don't-care.
        ex_d.valid     = 1'b0;
        ex_d.reg_write = 1'b0;
        ex_d.mem_read  = 1'b0;
        ex_d.mem_write = 1'b0;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        ex_d.valid     = id_valid;
        ex_d.reg_write = id_valid & id_reg_write;
        ex_d.mem_read  = id_valid & id_mem_read;
        ex_d.mem_write = id_valid & id_mem_write;
        ex_d.rd        = id_rd;
        ex_d.alu_ctrl  = id_alu_ctrl;
        ex_d.op_a      = fwd_a;
        ex_d.op_b      = fwd_b;
        ex_d.imm       = id_imm;
        ex_d.pc        = id_pc;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // its pre-edge value regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_rd        = ex_q.rd;
  assign ex_alu_ctrl  = ex_q.alu_ctrl;
  assign ex_op_a      = ex_q.op_a;
  assign ex_op_b      = ex_q.op_b;
  assign ex_imm       = ex_q.imm;
  assign ex_pc        = ex_q.pc;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// Scoreboard bench for id_ex_issue: directed vectors push the expected EX
// register contents; a monitor pops and compares after each rising edge.
module tb_id_ex_issue;

  typedef struct packed {
    logic        v, rw, mr, mw;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [31:0] a, b, imm, pc;
    logic [3:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_rs1, id_use_rs2;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [3:0]  id_alu_ctrl;
  logic [31:0] id_imm, id_pc;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_flush, ex_stall, id_stall;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_ctrl;
  logic [31:0] ex_op_a, ex_op_b, ex_imm, ex_pc;
  logic [3:0]  stall_cnt;

  exp_t exp_q[$];
  exp_t dut_vec;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  id_ex_issue #(.XLEN(32), .CTRL_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_ctrl(id_alu_ctrl), .id_imm(id_imm), .id_pc(id_pc),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_flush(ex_flush), .ex_stall(ex_stall), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .stall_cnt(stall_cnt)
  );

  assign dut_vec = '{v: ex_valid, rw: ex_reg_write, mr: ex_mem_read, mw: ex_mem_write,
                     rd: ex_rd, alu: ex_alu_ctrl, a: ex_op_a, b: ex_op_b,
                     imm: ex_imm, pc: ex_pc, cnt: stall_cnt};

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic exp_t mk(input logic v, rw, mr, mw, input logic [4:0] rd,
                              input logic [3:0] alu, input logic [31:0] a, b, imm, pc,
                              input logic [3:0] cnt);
    mk = '{v: v, rw: rw, mr: mr, mw: mw, rd: rd, alu: alu, a: a, b: b,
           imm: imm, pc: pc, cnt: cnt};
  endfunction

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rd = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_alu_ctrl = 0;
    id_imm = 0; id_pc = 0; rf_rdata1 = 0; rf_rdata2 = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    ex_flush = 0; ex_stall = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, mr, mw, input logic [3:0] alu,
                        input logic [31:0] imm, pc);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    id_alu_ctrl = alu; id_imm = imm; id_pc = pc;
  endtask

  task automatic set_rf(input logic [31:0] d1, d2);
    rf_rdata1 = d1; rf_rdata2 = d2;
  endtask

  task automatic set_byp(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    exmem_reg_write = ew; exmem_rd = erd; exmem_result = eres;
    memwb_reg_write = mw; memwb_rd = mrd; memwb_result = mres;
  endtask

  // Check id_stall for the current inputs and queue the post-edge EX state.
  task automatic expect_ex(input string name, input logic stall, input exp_t e);
    #1;
    check({name, "_id_stall"}, 160'(id_stall), 160'(stall));
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ex_regs", 160'(dut_vec), 160'(e));
      end
    end
  end

  initial begin : stimulus
    logic [3:0] cnt;
    idle();
    rst_n = 0;
    #1;
    check("reset_ex_regs", 160'(dut_vec), 160'(0));
    check("reset_id_stall", 160'(id_stall), 160'(0));
    @(negedge clk); rst_n = 1;

    // Forwarding priority on rs1: EX/MEM, then MEM/WB, then register file.
    @(negedge clk); idle(); set_id(1, 5, 1, 6, 1, 8, 1, 0, 0, 2, 32'h4, 32'h20);
    set_rf(32'h11, 32'h66); set_byp(1, 5, 32'h22, 1, 5, 32'h33);
    expect_ex("fwd_exmem", 0, mk(1, 1, 0, 0, 8, 2, 32'h22, 32'h66, 32'h4, 32'h20, 0));
    @(negedge clk); idle(); set_id(1, 5, 1, 6, 1, 8, 1, 0, 0, 2, 32'h4, 32'h20);
    set_rf(32'h11, 32'h66); set_byp(0, 5, 32'h22, 1, 5, 32'h33);
    expect_ex("fwd_memwb", 0, mk(1, 1, 0, 0, 8, 2, 32'h33, 32'h66, 32'h4, 32'h20, 0));
    @(negedge clk); idle(); set_id(1, 5, 1, 6, 1, 8, 1, 0, 0, 2, 32'h4, 32'h20);
    set_rf(32'h11, 32'h66); set_byp(0, 5, 32'h22, 0, 5, 32'h33);
    expect_ex("fwd_rf", 0, mk(1, 1, 0, 0, 8, 2, 32'h11, 32'h66, 32'h4, 32'h20, 0));
    @(negedge clk); idle(); set_id(1, 5, 1, 6, 1, 8, 1, 0, 0, 2, 32'h4, 32'h20);
    set_rf(32'h11, 32'h66); set_byp(1, 6, 32'h22, 1, 6, 32'h33);
    expect_ex("fwd_rs2_prio", 0, mk(1, 1, 0, 0, 8, 2, 32'h11, 32'h22, 32'h4, 32'h20, 0));
    // x0 never forwarded.
    @(negedge clk); idle(); set_id(1, 5, 1, 0, 1, 8, 1, 0, 0, 2, 32'h4, 32'h20);
    set_rf(32'h11, 32'h77); set_byp(1, 0, 32'hBEEF, 1, 0, 32'hDEAD);
    expect_ex("fwd_x0", 0, mk(1, 1, 0, 0, 8, 2, 32'h11, 32'h0, 32'h4, 32'h20, 0));
    // Invalid slot carries no writes.
    @(negedge clk); idle(); set_id(0, 5, 1, 6, 1, 10, 1, 0, 1, 7, 32'h99, 32'h30);
    set_rf(32'h11, 32'h66);
    expect_ex("invalid_slot", 0, mk(0, 0, 0, 0, 10, 7, 32'h11, 32'h66, 32'h99, 32'h30, 0));

    // Load-use on rs1: lw x7 then add x9,x7,x2.
    @(negedge clk); idle(); set_id(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 32'h8, 32'h40);
    set_rf(32'h1000, 32'h0);
    expect_ex("lw_x7", 0, mk(1, 1, 1, 0, 7, 0, 32'h1000, 32'h0, 32'h8, 32'h40, 0));
    @(negedge clk); idle(); set_id(1, 7, 1, 2, 1, 9, 1, 0, 0, 1, 32'h0, 32'h44);
    set_rf(32'h5, 32'h200);
    expect_ex("lu_bubble", 1, mk(0, 0, 0, 0, 7, 0, 32'h1000, 32'h0, 32'h8, 32'h40, 1));
    @(negedge clk); idle(); set_id(1, 7, 1, 2, 1, 9, 1, 0, 0, 1, 32'h0, 32'h44);
    set_rf(32'h5, 32'h200); set_byp(0, 0, 32'h0, 1, 7, 32'hCAFE);
    expect_ex("lu_capture", 0, mk(1, 1, 0, 0, 9, 1, 32'hCAFE, 32'h200, 32'h0, 32'h44, 1));
    // Load followed by a consumer whose matching rs1 is not used.
    @(negedge clk); idle(); set_id(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 32'h0, 32'h48);
    expect_ex("lw_x4", 0, mk(1, 1, 1, 0, 4, 0, 32'h0, 32'h0, 32'h0, 32'h48, 1));
    @(negedge clk); idle(); set_id(1, 4, 0, 3, 1, 5, 1, 0, 0, 3, 32'h0, 32'h4c);
    set_rf(32'h10, 32'h30);
    expect_ex("unused_rs1", 0, mk(1, 1, 0, 0, 5, 3, 32'h10, 32'h30, 32'h0, 32'h4c, 1));
    // Load-use on rs2.
    @(negedge clk); idle(); set_id(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 32'h0, 32'h50);
    expect_ex("lw_x4b", 0, mk(1, 1, 1, 0, 4, 0, 32'h0, 32'h0, 32'h0, 32'h50, 1));
    @(negedge clk); idle(); set_id(1, 0, 0, 4, 1, 6, 1, 0, 0, 2, 32'h0, 32'h54);
    set_rf(32'h0, 32'h44);
    expect_ex("lu_rs2", 1, mk(0, 0, 0, 0, 4, 0, 32'h0, 32'h0, 32'h0, 32'h50, 2));
    // Load to x0 never stalls.
    @(negedge clk); idle(); set_id(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0, 32'h58);
    expect_ex("lw_x0", 0, mk(1, 1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h58, 2));
    @(negedge clk); idle(); set_id(1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 32'h0, 32'h5c);
    expect_ex("use_x0", 0, mk(1, 1, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h5c, 2));

    // Flush beats stall.
    @(negedge clk); idle(); set_id(1, 0, 0, 0, 0, 2, 1, 0, 0, 5, 32'h60, 32'h60);
    expect_ex("pre_flush", 0, mk(1, 1, 0, 0, 2, 5, 32'h0, 32'h0, 32'h60, 32'h60, 2));
    @(negedge clk); idle(); set_id(1, 0, 0, 0, 0, 2, 1, 0, 0, 5, 32'h60, 32'h60);
    ex_flush = 1; ex_stall = 1;
    expect_ex("flush_stall", 0, mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 2));
    @(negedge clk); idle(); set_id(1, 5, 1, 6, 1, 3, 1, 0, 1, 6, 32'h70, 32'h70);
    set_rf(32'h55, 32'h66);
    expect_ex("pre_stall", 0, mk(1, 1, 0, 1, 3, 6, 32'h55, 32'h66, 32'h70, 32'h70, 2));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle(); set_id(1, 5, 1, 6, 1, 4, 1, 1, 0, 9, 32'h80, 32'h80);
      set_rf(32'h99, 32'h98); set_byp(1, 5, 32'h123, 0, 0, 32'h0); ex_stall = 1;
      expect_ex("stall_hold", 1, mk(1, 1, 0, 1, 3, 6, 32'h55, 32'h66, 32'h70, 32'h70, 2));
    end
    // Asynchronous reset while the back end is frozen.
    @(negedge clk); idle(); ex_stall = 1; rst_n = 0;
    #1;
    check("reset_mid_stall", 160'(dut_vec), 160'(0));
    @(negedge clk); idle(); rst_n = 1;

    // Saturating bubble counter (4-bit build).
    cnt = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); idle(); set_id(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 32'(i), 32'(i * 4));
      expect_ex("sat_lw", 0, mk(1, 1, 1, 0, 7, 0, 32'h0, 32'h0, 32'(i), 32'(i * 4), cnt));
      cnt = (cnt == 4'hF) ? 4'hF : cnt + 4'h1;
      @(negedge clk); idle(); set_id(1, 7, 1, 0, 0, 9, 1, 0, 0, 1, 32'h0, 32'h0);
      expect_ex("sat_bubble", 1, mk(0, 0, 0, 0, 7, 0, 32'h0, 32'h0, 32'(i), 32'(i * 4), cnt));
    end
    @(negedge clk); idle();
    check("stall_cnt_sat", 160'(stall_cnt), 160'(4'hF));

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
